camerica_line_capture: RTL and testbench
========================================

// Module: camerica_line_capture
// PURPOSE
// Parametrised line-capture engine for the camera path. Takes camera pixels
// already synchronised into the clk domain and packs them into 64-bit words.
// Writes each line into an NUM_BUFS-deep ring of line buffers. Exposes the
// buffers on a vm_* read port and control/status/IRQ on an nr_* register port.
// Sits between the camera bus synchroniser and the Qsys interconnect.
// PARAMETERS
// PIX_W       12  pixel width in bits, 1..16; each pixel occupies a 16-bit lane
// LINE_WORDS  64  64-bit words per line (4*LINE_WORDS pixels), power of 2
// NUM_BUFS    4   line buffers in ring, power of 2, >=2
// VM_AW       8   vm_address width = log2(NUM_BUFS*LINE_WORDS)
// PORTS
// clk            in   1      50MHz system clock
// rst            in   1      synchronous reset, active high
// cam_valid      in   1      cam_pixel/cam_hsync/cam_vsync valid this cycle
// cam_pixel      in   PIX_W  pixel data
// cam_hsync      in   1      line start, sampled when cam_valid
// cam_vsync      in   1      frame start, sampled when cam_valid
// nr_acknowledge out  1      register access done (1-cycle pulse)
// nr_irq         out  1      line-ready interrupt, level
// nr_address     in   2      0 CTRL, 1 STATUS, 2 RELEASE, 3 COUNTERS
// nr_bus_enable  in   1      access request, held until acknowledge
// nr_rw          in   1      1 read, 0 write
// nr_write_data  in   32     write data
// nr_read_data   out  32     read data, valid with nr_acknowledge
// vm_acknowledge out  1      vid-mem read done (1-cycle pulse)
// vm_address     in   VM_AW  {buffer index, word index}
// vm_bus_enable  in   1      read request, held until acknowledge
// vm_rw          in   1      must be 1 (read); writes acked, ignored
// vm_read_data   out  64     buffer word, valid with vm_acknowledge
// BEHAVIOUR
// - Reset: all outputs 0; state IDLE; fill=0, wr_idx=0, rd_idx=0; flags, counters, CTRL = 0.
// - FSM (advances only on cam_valid, except IDLE exit):
//   IDLE -CTRL.en=1-> WAIT_VSYNC -vsync-> WAIT_HSYNC -hsync-> CAPTURE | DROP.
//   CAPTURE is entered only if fill<NUM_BUFS. Else DROP, ovf flag set, drop_cnt++.
//   CAPTURE: the hsync cycle carries pixel 0. Pixel k goes to lane k%4 as [16*lane+PIX_W-1:16*lane]. Unused lane bits are 0.
//   The word is written to buffer wr_idx, word k/4, when lane 3 is filled.
//   After word LINE_WORDS-1 is written: wr_idx++ (mod NUM_BUFS), fill++, line_cnt++, irq_pend=1 -> WAIT_HSYNC.
//   DROP: ignores pixels until the next hsync.
//   hsync during CAPTURE: line abandoned, short flag set, wr_idx unchanged, restart capture (same rules).
//   vsync in any non-IDLE state: abandon line, frame_cnt++, line_cnt=0 -> WAIT_HSYNC.
//   CTRL.en=0: -> IDLE immediately; a partial line is discarded. Buffers and fill are untouched.
// - Registers:
//   CTRL   [0] en, [1] irq_en (R/W).
//   STATUS (R) [7:0] fill, [15:8] rd_idx, [23:16] wr_idx, [24] ovf, [25] short, [26] irq_pend.
//          (W) 1-to-clear on bits 24..26.
//   RELEASE (W any value): if fill>0 then fill--, rd_idx++; else ignored. Reads return 0.
//   COUNTERS (R) [15:0] line_cnt, [23:16] frame_cnt (wraps), [31:24] drop_cnt (saturates at 255).
// - nr_irq = irq_pend & irq_en, registered.
// - Line completion and RELEASE in the same cycle: fill unchanged, both indices advance.
//   Completion beats a same-cycle STATUS W1C of irq_pend (stays set).
// - Handshakes: acknowledge is asserted the cycle after bus_enable is first seen and lasts 1 cycle.
//   Exactly 1 ack per request. Read data is valid in the ack cycle and held until the next ack.
//   vm read is 2 cycles from enable to data (registered RAM output).
// - vm reads of the buffer under capture return whatever was last written; no protection.
// - Buffer RAM: NUM_BUFS*LINE_WORDS x 64, 1 write port (capture), 1 read port (vm).
// TESTING
// - Enable, vsync, 1 full line of pixels 0..255 (PIX_W=12) -> fill=1, irq=1; vm addr 0 reads 0x0003_0002_0001_0000.
// - 5 lines with no RELEASE (NUM_BUFS=4) -> fill=4, ovf=1, drop_cnt=1; the 5th line is not written.
// - hsync after 100 pixels, then full line -> short=1, fill=1; buffer 0 holds the full line.
// - RELEASE on the same cycle as line completion with fill=2 -> fill=2, rd_idx+1, wr_idx+1.
// - RELEASE with fill=0 -> fill=0, rd_idx unchanged; acknowledge still pulses once.
// - rst asserted mid-line -> all outputs 0, FSM IDLE, fill=0; the next line is ignored until CTRL.en is rewritten.

Source files
------------

// File: rtl/camerica_line_capture_if.sv
// Bus bundle for camerica_line_capture: synchronised camera pixel stream, the nr_* register
// port and the vm_* line-buffer read port. The capture engine takes the slave side.
interface camerica_line_capture_if #(
  parameter int unsigned PIX_W = 12,
  parameter int unsigned VM_AW = 8
);
  // Camera stream, already in the clk domain
  logic             cam_valid;
  logic [PIX_W-1:0] cam_pixel;
  logic             cam_hsync;
  logic             cam_vsync;

  // Control/status register port
  logic             nr_acknowledge;
  logic             nr_irq;
  logic [1:0]       nr_address;
  logic             nr_bus_enable;
  logic             nr_rw;
  logic [31:0]      nr_write_data;
  logic [31:0]      nr_read_data;

  // Line-buffer read port
  logic             vm_acknowledge;
  logic [VM_AW-1:0] vm_address;
  logic             vm_bus_enable;
  logic             vm_rw;
  logic [63:0]      vm_read_data;

  modport slave (
    input  cam_valid, cam_pixel, cam_hsync, cam_vsync,
    input  nr_address, nr_bus_enable, nr_rw, nr_write_data,
    output nr_acknowledge, nr_irq, nr_read_data,
    input  vm_address, vm_bus_enable, vm_rw,
    output vm_acknowledge, vm_read_data
  );

  modport master (
    output cam_valid, cam_pixel, cam_hsync, cam_vsync,
    output nr_address, nr_bus_enable, nr_rw, nr_write_data,
    input  nr_acknowledge, nr_irq, nr_read_data,
    output vm_address, vm_bus_enable, vm_rw,
    input  vm_acknowledge, vm_read_data
  );
endinterface

// File: rtl/camerica_line_capture.sv
// Line-capture engine: packs camera pixels four per 64-bit word into a ring of line buffers,
// with a register port for control/status/IRQ and a registered read port onto the buffers.
module camerica_line_capture #(
  parameter int unsigned PIX_W      = 12,
  parameter int unsigned LINE_WORDS = 64,
  parameter int unsigned NUM_BUFS   = 4,
  parameter int unsigned VM_AW      = 8
) (
  input logic                     clk,
  input logic                     rst,
  camerica_line_capture_if.slave  bus
);

  localparam int unsigned BufW  = $clog2(NUM_BUFS);
  localparam int unsigned WordW = $clog2(LINE_WORDS);
  localparam int unsigned Depth = NUM_BUFS * LINE_WORDS;

  localparam logic [BufW:0]    FullFill = (BufW + 1)'(NUM_BUFS);
  localparam logic [WordW-1:0] LastWord = WordW'(LINE_WORDS - 1);

  localparam logic [2:0] StIdle      = 3'd0;
  localparam logic [2:0] StWaitVsync = 3'd1;
  localparam logic [2:0] StWaitHsync = 3'd2;
  localparam logic [2:0] StCapture   = 3'd3;
  localparam logic [2:0] StDrop      = 3'd4;

  localparam logic [1:0] AddrCtrl     = 2'd0;
  localparam logic [1:0] AddrStatus   = 2'd1;
  localparam logic [1:0] AddrRelease  = 2'd2;
  localparam logic [1:0] AddrCounters = 2'd3;

  // Capture state
  logic [2:0]       state_q, state_d;
  logic [63:0]      word_q, word_d;
  logic [1:0]       lane_q, lane_d;
  logic [WordW-1:0] word_idx_q, word_idx_d;
  logic [15:0]      pix_ext;

  // Ring bookkeeping, flags and counters
  logic [1:0]       ctrl_q;
  logic [BufW:0]    fill_q;
  logic [BufW-1:0]  wr_idx_q, rd_idx_q;
  logic             ovf_q, short_q, irq_pend_q, irq_q;
  logic [15:0]      line_cnt_q;
  logic [7:0]       frame_cnt_q, drop_cnt_q;

  logic             line_done, line_drop, line_short, frame_start;

  // Register port
  logic             nr_ack_q;
  logic [31:0]      nr_rdata_q, nr_rdata;
  logic             nr_go, nr_wr, release_ok, status_w1c;

  // Buffer RAM and read port
  logic [63:0]               mem [Depth];
  logic                      mem_we;
  logic [BufW+WordW-1:0]     mem_waddr;
  logic [63:0]               ram_q;
  logic                      vm_go, vm_pend_q, vm_is_rd_q, vm_ack_q;
  logic [63:0]               vm_rdata_q;
  logic                      unused_wdata;

  assign pix_ext   = 16'(bus.cam_pixel);
  assign mem_waddr = {wr_idx_q, word_idx_q};

  // The hsync beat carries pixel 0; a full word is written when lane 3 lands.
  always_comb begin
    state_d     = state_q;
    word_d      = word_q;
    lane_d      = lane_q;
    word_idx_d  = word_idx_q;
    mem_we      = 1'b0;
    line_done   = 1'b0;
    line_drop   = 1'b0;
    line_short  = 1'b0;
    frame_start = 1'b0;
    if (!ctrl_q[0]) begin
      state_d = StIdle;
    end else if (state_q == StIdle) begin
      state_d = StWaitVsync;
    end else if (bus.cam_valid) begin
      if (bus.cam_vsync) begin
        frame_start = 1'b1;
        state_d     = StWaitHsync;
      end else if (bus.cam_hsync && (state_q != StWaitVsync)) begin
        line_short = (state_q == StCapture);
        if (fill_q < FullFill) begin
          state_d      = StCapture;
          word_d[15:0] = pix_ext;
          lane_d       = 2'd1;
          word_idx_d   = '0;
        end else begin
          state_d   = StDrop;
          line_drop = 1'b1;
        end
      end else if (state_q == StCapture) begin
        word_d[16*lane_q +: 16] = pix_ext;
        lane_d                  = lane_q + 2'd1;
        if (lane_q == 2'd3) begin
          mem_we = 1'b1;
          if (word_idx_q == LastWord) begin
            line_done = 1'b1;
            state_d   = StWaitHsync;
          end else begin
            word_idx_d = word_idx_q + 1'b1;
          end
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StIdle;
      word_q     <= '0;
      lane_q     <= '0;
      word_idx_q <= '0;
    end else begin
      state_q    <= state_d;
      word_q     <= word_d;
      lane_q     <= lane_d;
      word_idx_q <= word_idx_d;
    end
  end

  // One access per request: the ack cycle itself never starts a new one.
  assign nr_go      = bus.nr_bus_enable & ~nr_ack_q;
  assign nr_wr      = nr_go & ~bus.nr_rw;
  assign release_ok = nr_wr & (bus.nr_address == AddrRelease) & (fill_q != '0);
  assign status_w1c = nr_wr & (bus.nr_address == AddrStatus);

  always_comb begin
    nr_rdata = '0;
    unique case (bus.nr_address)
      AddrCtrl:     nr_rdata = {30'd0, ctrl_q};
      AddrStatus:   nr_rdata = {5'd0, irq_pend_q, short_q, ovf_q,
                                8'(wr_idx_q), 8'(rd_idx_q), 8'(fill_q)};
      AddrRelease:  nr_rdata = '0;
      AddrCounters: nr_rdata = {drop_cnt_q, frame_cnt_q, line_cnt_q};
      default:      nr_rdata = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      nr_ack_q   <= 1'b0;
      nr_rdata_q <= '0;
      ctrl_q     <= '0;
    end else begin
      nr_ack_q <= nr_go;
      if (nr_go && bus.nr_rw) begin
        nr_rdata_q <= nr_rdata;
      end
      if (nr_wr && (bus.nr_address == AddrCtrl)) begin
        ctrl_q <= bus.nr_write_data[1:0];
      end
    end
  end

  // Events that set a flag win over a same-cycle write-1-to-clear.
  always_ff @(posedge clk) begin
    if (rst) begin
      fill_q      <= '0;
      wr_idx_q    <= '0;
      rd_idx_q    <= '0;
      ovf_q       <= 1'b0;
      short_q     <= 1'b0;
      irq_pend_q  <= 1'b0;
      irq_q       <= 1'b0;
      line_cnt_q  <= '0;
      frame_cnt_q <= '0;
      drop_cnt_q  <= '0;
    end else begin
      if (line_done && !release_ok) begin
        fill_q <= fill_q + 1'b1;
      end else if (release_ok && !line_done) begin
        fill_q <= fill_q - 1'b1;
      end
      if (line_done) begin
        wr_idx_q <= wr_idx_q + 1'b1;
      end
      if (release_ok) begin
        rd_idx_q <= rd_idx_q + 1'b1;
      end

      if (line_drop) begin
        ovf_q <= 1'b1;
      end else if (status_w1c && bus.nr_write_data[24]) begin
        ovf_q <= 1'b0;
      end
      if (line_short) begin
        short_q <= 1'b1;
      end else if (status_w1c && bus.nr_write_data[25]) begin
        short_q <= 1'b0;
      end
      if (line_done) begin
        irq_pend_q <= 1'b1;
      end else if (status_w1c && bus.nr_write_data[26]) begin
        irq_pend_q <= 1'b0;
      end
      irq_q <= irq_pend_q & ctrl_q[1];

      if (frame_start) begin
        line_cnt_q  <= '0;
        frame_cnt_q <= frame_cnt_q + 8'd1;
      end else if (line_done) begin
        line_cnt_q <= line_cnt_q + 16'd1;
      end
      if (line_drop && (drop_cnt_q != 8'hff)) begin
        drop_cnt_q <= drop_cnt_q + 8'd1;
      end
    end
  end

  // Read port: RAM read registered on the request edge, ack and data one cycle later.
  assign vm_go = bus.vm_bus_enable & ~vm_pend_q & ~vm_ack_q;

  always_ff @(posedge clk) begin
    if (mem_we && !rst) begin
      mem[mem_waddr] <= word_d;
    end
    if (vm_go) begin
      ram_q <= mem[bus.vm_address];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      vm_pend_q  <= 1'b0;
      vm_is_rd_q <= 1'b0;
      vm_ack_q   <= 1'b0;
      vm_rdata_q <= '0;
    end else begin
      vm_ack_q <= vm_pend_q;
      if (vm_go) begin
        vm_pend_q  <= 1'b1;
        vm_is_rd_q <= bus.vm_rw;
      end else begin
        vm_pend_q <= 1'b0;
      end
      if (vm_pend_q && vm_is_rd_q) begin
        vm_rdata_q <= ram_q;
      end
    end
  end

  assign bus.nr_acknowledge = nr_ack_q;
  assign bus.nr_read_data   = nr_rdata_q;
  assign bus.nr_irq         = irq_q;
  assign bus.vm_acknowledge = vm_ack_q;
  assign bus.vm_read_data   = vm_rdata_q;

  assign unused_wdata = ^{bus.nr_write_data[31:27], bus.nr_write_data[23:2]};

endmodule

// File: tb/tb_camerica_line_capture.sv
// Directed-sequence bench for camerica_line_capture with randomised pixels and gaps,
// checked against a line-level model of the ring, flags, counters and buffer contents.
module tb_camerica_line_capture;

  localparam int unsigned PixW      = 12;
  localparam int unsigned LineWords = 64;
  localparam int unsigned NumBufs   = 4;
  localparam int unsigned VmAw      = 8;
  localparam int          LinePix   = 4 * LineWords;

  logic clk = 1'b0;
  logic rst;
  always #10 clk = ~clk;

  camerica_line_capture_if #(.PIX_W(PixW), .VM_AW(VmAw)) bus ();

  camerica_line_capture #(
    .PIX_W      (PixW),
    .LINE_WORDS (LineWords),
    .NUM_BUFS   (NumBufs),
    .VM_AW      (VmAw)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int tests = 0;
  int fails = 0;

  // Reference model
  logic [63:0] exp_mem [NumBufs*LineWords];
  bit          m_en, m_armed, m_cap, m_ovf, m_short, m_irq;
  int          m_fill, m_wr, m_rd, m_line, m_frame, m_drop, m_pix;
  logic [63:0] m_word;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed 0x%h expected 0x%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic void m_reset();
    m_en = 0; m_armed = 0; m_cap = 0; m_ovf = 0; m_short = 0; m_irq = 0;
    m_fill = 0; m_wr = 0; m_rd = 0; m_line = 0; m_frame = 0; m_drop = 0; m_pix = 0;
  endfunction

  function automatic void m_ctrl(input logic [31:0] v);
    m_en = v[0];
    if (!m_en) begin
      m_armed = 0;
      m_cap   = 0;
    end
  endfunction

  function automatic void m_release();
    if (m_fill > 0) begin
      m_fill--;
      m_rd = (m_rd + 1) % NumBufs;
    end
  endfunction

  function automatic void m_w1c(input logic [31:0] v);
    if (v[24]) m_ovf = 0;
    if (v[25]) m_short = 0;
    if (v[26]) m_irq = 0;
  endfunction

  function automatic void m_cam(input int p, input bit hs, input bit vs);
    int lane;
    if (!m_en) return;
    if (vs) begin
      m_frame = (m_frame + 1) % 256;
      m_line  = 0;
      m_cap   = 0;
      m_armed = 1;
      return;
    end
    if (!m_armed) return;
    if (hs) begin
      if (m_cap) m_short = 1;
      if (m_fill < NumBufs) begin
        m_cap = 1;
        m_pix = 0;
      end else begin
        m_cap = 0;
        m_ovf = 1;
        if (m_drop < 255) m_drop++;
      end
    end
    if (!m_cap) return;
    lane = m_pix % 4;
    if (lane == 0) m_word = '0;
    m_word = m_word | (64'(p) << (16 * lane));
    if (lane == 3) exp_mem[m_wr*LineWords + m_pix/4] = m_word;
    m_pix++;
    if (m_pix == LinePix) begin
      m_cap  = 0;
      m_wr   = (m_wr + 1) % NumBufs;
      m_fill++;
      m_line = (m_line + 1) % 65536;
      m_irq  = 1;
    end
  endfunction

  function automatic logic [63:0] exp_status();
    return 64'(m_fill) | (64'(m_rd) << 8) | (64'(m_wr) << 16) | (64'(m_ovf) << 24)
         | (64'(m_short) << 25) | (64'(m_irq) << 26);
  endfunction

  function automatic logic [63:0] exp_counters();
    return 64'(m_line) | (64'(m_frame) << 16) | (64'(m_drop) << 24);
  endfunction

  // Register access; checks that the ack arrives within budget and pulses exactly once.
  task automatic nr_xfer(input logic [1:0] a, input logic rw, input logic [31:0] wd,
                         output logic [31:0] rd);
    int n = 0;
    bus.nr_address = a; bus.nr_rw = rw; bus.nr_write_data = wd; bus.nr_bus_enable = 1'b1;
    do begin
      tick();
      n++;
    end while (!bus.nr_acknowledge && n < 20);
    check("nr_ack", 64'(bus.nr_acknowledge), 64'd1);
    rd = bus.nr_read_data;
    bus.nr_bus_enable = 1'b0;
    tick();
    check("nr_ack_once", 64'(bus.nr_acknowledge), 64'd0);
  endtask

  task automatic reg_write(input logic [1:0] a, input logic [31:0] wd);
    logic [31:0] dummy;
    nr_xfer(a, 1'b0, wd, dummy);
    case (a)
      2'd0: m_ctrl(wd);
      2'd1: m_w1c(wd);
      2'd2: m_release();
      default: ;
    endcase
  endtask

  task automatic check_regs(input string tag);
    logic [31:0] d;
    nr_xfer(2'd1, 1'b1, 32'd0, d);
    check({tag, "_status"}, 64'(d), exp_status());
    nr_xfer(2'd3, 1'b1, 32'd0, d);
    check({tag, "_counters"}, 64'(d), exp_counters());
  endtask

  task automatic vm_xfer(input int a, input logic rw, output logic [63:0] d);
    int n = 0;
    bus.vm_address = VmAw'(a); bus.vm_rw = rw; bus.vm_bus_enable = 1'b1;
    do begin
      tick();
      n++;
    end while (!bus.vm_acknowledge && n < 20);
    check("vm_ack", 64'(bus.vm_acknowledge), 64'd1);
    d = bus.vm_read_data;
    bus.vm_bus_enable = 1'b0;
    tick();
    check("vm_ack_once", 64'(bus.vm_acknowledge), 64'd0);
  endtask

  task automatic check_vm(input int a);
    logic [63:0] d;
    vm_xfer(a, 1'b1, d);
    check($sformatf("vm_word_%0d", a), d, exp_mem[a]);
  endtask

  // One camera beat, optionally preceded by an idle cycle carrying junk on the bus.
  task automatic cam_beat(input int p, input bit hs, input bit vs, input bit gaps);
    if (gaps && $urandom_range(3) == 0) begin
      bus.cam_valid = 1'b0;
      bus.cam_pixel = PixW'($urandom);
      bus.cam_hsync = 1'($urandom);
      bus.cam_vsync = 1'($urandom);
      tick();
    end
    bus.cam_valid = 1'b1; bus.cam_pixel = PixW'(p); bus.cam_hsync = hs; bus.cam_vsync = vs;
    tick();
    m_cam(p, hs, vs);
    bus.cam_valid = 1'b0; bus.cam_hsync = 1'b0; bus.cam_vsync = 1'b0;
  endtask

  task automatic send_pixels(input int n, input bit rnd);
    for (int i = 0; i < n; i++) begin
      cam_beat(rnd ? int'($urandom_range(4095)) : i, (i == 0), 1'b0, 1'b1);
    end
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_nr_ack"}, 64'(bus.nr_acknowledge), 64'd0);
    check({tag, "_nr_irq"}, 64'(bus.nr_irq), 64'd0);
    check({tag, "_nr_rdata"}, 64'(bus.nr_read_data), 64'd0);
    check({tag, "_vm_ack"}, 64'(bus.vm_acknowledge), 64'd0);
    check({tag, "_vm_rdata"}, bus.vm_read_data, 64'd0);
  endtask

  initial begin
    logic [31:0] d32;
    logic [63:0] d64;

    bus.cam_valid = 0; bus.cam_pixel = '0; bus.cam_hsync = 0; bus.cam_vsync = 0;
    bus.nr_address = '0; bus.nr_bus_enable = 0; bus.nr_rw = 0; bus.nr_write_data = '0;
    bus.vm_address = '0; bus.vm_bus_enable = 0; bus.vm_rw = 0;
    m_reset();
    rst = 1'b1;
    repeat (3) tick();
    rst = 1'b0;
    tick();

    check_idle_outputs("reset");
    check_regs("reset");
    nr_xfer(2'd0, 1'b1, 32'd0, d32);
    check("reset_ctrl", 64'(d32), 64'd0);

    // Single ramp line
    reg_write(2'd0, 32'h3);
    cam_beat(0, 1'b0, 1'b1, 1'b1);
    send_pixels(LinePix, 1'b0);
    check_regs("line1");
    repeat (2) tick();
    check("line1_irq", 64'(bus.nr_irq), 64'd1);
    vm_xfer(0, 1'b1, d64);
    check("line1_word0", d64, 64'h0003_0002_0001_0000);
    check_vm(63);

    // Fill the ring, then one line too many
    repeat (3) send_pixels(LinePix, 1'b1);
    nr_xfer(2'd1, 1'b1, 32'd0, d32);
    check("ring_full_fill", 64'(d32[7:0]), 64'd4);
    send_pixels(LinePix, 1'b1);
    check_regs("overflow");
    for (int b = 0; b < NumBufs; b++) begin
      check_vm(b * LineWords + int'($urandom_range(LineWords - 1)));
      check_vm(b * LineWords + LineWords - 1);
    end

    // Release and completion on the same edge
    reg_write(2'd2, 32'd0);
    reg_write(2'd2, 32'd0);
    reg_write(2'd1, 32'h0700_0000);
    send_pixels(LinePix - 1, 1'b1);
    bus.nr_address = 2'd2; bus.nr_rw = 1'b0; bus.nr_write_data = $urandom; bus.nr_bus_enable = 1;
    bus.cam_valid = 1'b1; bus.cam_pixel = 12'h5a5;
    tick();
    m_release();
    m_cam(32'h5a5, 1'b0, 1'b0);
    bus.cam_valid = 1'b0;
    check("simul_ack", 64'(bus.nr_acknowledge), 64'd1);
    bus.nr_bus_enable = 1'b0;
    tick();
    check("simul_ack_once", 64'(bus.nr_acknowledge), 64'd0);
    check_regs("simul");
    nr_xfer(2'd1, 1'b1, 32'd0, d32);
    check("simul_fields", 64'(d32[23:0]), 64'h01_03_02);
    check_vm(LineWords - 1);

    // Short line followed by a full one in the same buffer
    reg_write(2'd1, 32'h0700_0000);
    send_pixels(100, 1'b1);
    send_pixels(LinePix, 1'b1);
    check_regs("short");
    check_vm(1 * LineWords + 5);
    check_vm(1 * LineWords + 24);
    check_vm(1 * LineWords + 25);

    // Drain the ring, then release an empty ring
    repeat (3) reg_write(2'd2, 32'd0);
    reg_write(2'd2, 32'hffff_ffff);
    check_regs("empty_release");
    nr_xfer(2'd2, 1'b1, 32'd0, d32);
    check("release_reads_zero", 64'(d32), 64'd0);

    // vm writes are acknowledged but change nothing
    vm_xfer(2 * LineWords + 7, 1'b0, d64);
    check_vm(2 * LineWords + 7);

    // vsync mid-line abandons it and restarts the line count
    send_pixels(50, 1'b1);
    cam_beat(0, 1'b0, 1'b1, 1'b0);
    check_regs("vsync_mid");
    send_pixels(LinePix, 1'b1);
    check_regs("after_vsync");
    check_vm(2 * LineWords + int'($urandom_range(LineWords - 1)));

    // irq_en masks the interrupt line
    reg_write(2'd0, 32'h1);
    repeat (2) tick();
    check("irq_masked", 64'(bus.nr_irq), 64'd0);
    reg_write(2'd0, 32'h3);
    repeat (2) tick();
    check("irq_unmasked", 64'(bus.nr_irq), 64'd1);

    // Reset mid-line
    send_pixels(30, 1'b1);
    rst = 1'b1;
    repeat (2) tick();
    rst = 1'b0;
    m_reset();
    check_idle_outputs("rst_mid");
    check_regs("rst_mid");
    cam_beat(0, 1'b0, 1'b1, 1'b0);
    send_pixels(LinePix, 1'b1);
    check_regs("rst_ignored");
    reg_write(2'd0, 32'h1);
    cam_beat(0, 1'b0, 1'b1, 1'b0);
    send_pixels(LinePix, 1'b1);
    check_regs("rst_reenabled");
    check_vm(17);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
